// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one single-cycle 32-bit ALU between two
//             requesters. Each operation is accepted via valid/ready, runs
//             from registered operands for one cycle, and its result returns
//             on a registered per-requester response handshake.
//  Options  : ALU_ARB_PERF_EN - builds saturating per-requester grant
//             counters; without it the counter ports are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  // requester 0
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [31:0]       req0_a_i32,
  input  logic [31:0]       req0_b_i32,
  input  logic [5:0]        req0_funct_i6,
  input  logic [1:0]        req0_alt_ctrl_i2,
  // requester 1
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [31:0]       req1_a_i32,
  input  logic [31:0]       req1_b_i32,
  input  logic [5:0]        req1_funct_i6,
  input  logic [1:0]        req1_alt_ctrl_i2,
  // response channel
  output logic              rsp0_valid_o,
  output logic              rsp1_valid_o,
  input  logic              rsp0_ready_i,
  input  logic              rsp1_ready_i,
  output logic [31:0]       rsp_y_o32,
  output logic              rsp_zero_o,
  // ALU interface
  output logic [31:0]       alu_a_o32,
  output logic [31:0]       alu_b_o32,
  output logic [5:0]        alu_funct_o6,
  output logic [1:0]        alu_alt_ctrl_o2,
  input  logic [31:0]       alu_y_i32,
  input  logic              alu_zero_i,
  // status
  output logic              busy_o,
  output logic [CNT_W-1:0]  grant_cnt0_o,
  output logic [CNT_W-1:0]  grant_cnt1_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t       state_q;
  logic [31:0]  a_q;
  logic [31:0]  b_q;
  logic [5:0]   funct_q;
  logic [1:0]   alt_q;
  logic         gid_q;
  logic         last_gid_q;
  logic [31:0]  res_y_q;
  logic         res_zero_q;
  logic         rsp0_valid_q;
  logic         rsp1_valid_q;

  logic         win_valid;
  logic         win_id;
  logic         accept;
  logic         rsp_done;

  // Arbitration: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    win_valid = req0_valid_i | req1_valid_i;
    win_id    = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      win_id = ~last_gid_q;
    end else if (req1_valid_i) begin
      win_id = 1'b1;
    end
    // Reset masks ready so nothing is advertised while the block is clearing.
    accept       = (state_q == S_IDLE) && win_valid && !reset_i;
    req0_ready_o = accept && !win_id;
    req1_ready_o = accept &&  win_id;
    rsp_done     = (rsp0_valid_q && rsp0_ready_i) || (rsp1_valid_q && rsp1_ready_i);
  end

  // Control FSM with operand, result and response-valid registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      funct_q      <= 6'd0;
      alt_q        <= 2'd0;
      gid_q        <= 1'b0;
      last_gid_q   <= 1'b1;
      res_y_q      <= 32'd0;
      res_zero_q   <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            a_q        <= win_id ? req1_a_i32       : req0_a_i32;
            b_q        <= win_id ? req1_b_i32       : req0_b_i32;
            funct_q    <= win_id ? req1_funct_i6    : req0_funct_i6;
            alt_q      <= win_id ? req1_alt_ctrl_i2 : req0_alt_ctrl_i2;
            gid_q      <= win_id;
            last_gid_q <= win_id;
            state_q    <= S_EXEC;
          end
        end
        S_EXEC: begin
          // ALU is combinational on the op regs, so its result is ready now.
          res_y_q      <= alu_y_i32;
          res_zero_q   <= alu_zero_i;
          rsp0_valid_q <= !gid_q;
          rsp1_valid_q <=  gid_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (rsp_done) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a_o32       = a_q;
  assign alu_b_o32       = b_q;
  assign alu_funct_o6    = funct_q;
  assign alu_alt_ctrl_o2 = alt_q;
  assign rsp0_valid_o    = rsp0_valid_q;
  assign rsp1_valid_o    = rsp1_valid_q;
  assign rsp_y_o32       = res_y_q;
  assign rsp_zero_o      = res_zero_q;
  assign busy_o          = (state_q != S_IDLE);

`ifdef ALU_ARB_PERF_EN
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Saturating grant counters, stepped on each accept handshake.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
    end else begin
      if (req0_ready_o && req0_valid_i && (cnt0_q != C_CNT_MAX)) begin
        cnt0_q <= cnt0_q + C_CNT_ONE;
      end
      if (req1_ready_o && req1_valid_i && (cnt1_q != C_CNT_MAX)) begin
        cnt1_q <= cnt1_q + C_CNT_ONE;
      end
    end
  end

  assign grant_cnt0_o = cnt0_q;
  assign grant_cnt1_o = cnt1_q;
`else
  assign grant_cnt0_o = {CNT_W{1'b0}};
  assign grant_cnt1_o = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_arbiter
//  Purpose  : Directed self-checking bench for alu_arbiter with a small
//             behavioural ALU (ADD 0x20, SUB 0x22).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset_i;
  logic             req0_valid_i, req1_valid_i;
  logic             req0_ready_o, req1_ready_o;
  logic [31:0]      req0_a_i32, req0_b_i32, req1_a_i32, req1_b_i32;
  logic [5:0]       req0_funct_i6, req1_funct_i6;
  logic [1:0]       req0_alt_ctrl_i2, req1_alt_ctrl_i2;
  logic             rsp0_valid_o, rsp1_valid_o;
  logic             rsp0_ready_i, rsp1_ready_i;
  logic [31:0]      rsp_y_o32;
  logic             rsp_zero_o;
  logic [31:0]      alu_a_o32, alu_b_o32;
  logic [5:0]       alu_funct_o6;
  logic [1:0]       alu_alt_ctrl_o2;
  logic [31:0]      alu_y_i32;
  logic             alu_zero_i;
  logic             busy_o;
  logic [CNT_W-1:0] grant_cnt0_o, grant_cnt1_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_a_i32(req0_a_i32), .req0_b_i32(req0_b_i32),
    .req0_funct_i6(req0_funct_i6), .req0_alt_ctrl_i2(req0_alt_ctrl_i2),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_a_i32(req1_a_i32), .req1_b_i32(req1_b_i32),
    .req1_funct_i6(req1_funct_i6), .req1_alt_ctrl_i2(req1_alt_ctrl_i2),
    .rsp0_valid_o(rsp0_valid_o), .rsp1_valid_o(rsp1_valid_o),
    .rsp0_ready_i(rsp0_ready_i), .rsp1_ready_i(rsp1_ready_i),
    .rsp_y_o32(rsp_y_o32), .rsp_zero_o(rsp_zero_o),
    .alu_a_o32(alu_a_o32), .alu_b_o32(alu_b_o32),
    .alu_funct_o6(alu_funct_o6), .alu_alt_ctrl_o2(alu_alt_ctrl_o2),
    .alu_y_i32(alu_y_i32), .alu_zero_i(alu_zero_i),
    .busy_o(busy_o),
    .grant_cnt0_o(grant_cnt0_o), .grant_cnt1_o(grant_cnt1_o)
  );

  // Behavioural single-cycle ALU standing in for the shared one.
  always_comb begin
    alu_y_i32 = alu_a_o32 ^ alu_b_o32;
    if (alu_funct_o6 == 6'h20) alu_y_i32 = alu_a_o32 + alu_b_o32;
    if (alu_funct_o6 == 6'h22) alu_y_i32 = alu_a_o32 - alu_b_o32;
    alu_zero_i = (alu_y_i32 == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic [31:0] a,
                       input logic [31:0] b, input logic [5:0] f);
    if (id == 0) begin
      req0_valid_i = v; req0_a_i32 = a; req0_b_i32 = b; req0_funct_i6 = f;
    end else begin
      req1_valid_i = v; req1_a_i32 = a; req1_b_i32 = b; req1_funct_i6 = f;
    end
  endtask

  // Full transaction for one requester: accept, EXEC, RESP, response handshake.
  task automatic run_op(input string tag, input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic [5:0] f,
                        input logic [31:0] exp_y, input logic exp_z);
    int n;
    logic rdy;
    drive(id, 1'b1, a, b, f);
    #1;
    n = 0;
    rdy = (id == 0) ? req0_ready_o : req1_ready_o;
    while (!rdy && n < 20) begin
      tick();
      n++;
      rdy = (id == 0) ? req0_ready_o : req1_ready_o;
    end
    check({tag, "_ready"}, {31'd0, rdy}, 32'd1);
    tick();
    drive(id, 1'b0, 32'd0, 32'd0, 6'd0);
    check({tag, "_exec_busy"}, {31'd0, busy_o}, 32'd1);
    check({tag, "_exec_norsp"}, {30'd0, rsp1_valid_o, rsp0_valid_o}, 32'd0);
    tick();
    check({tag, "_rsp_valid"}, {30'd0, rsp1_valid_o, rsp0_valid_o}, (id == 0) ? 32'd1 : 32'd2);
    check({tag, "_y"}, rsp_y_o32, exp_y);
    check({tag, "_zero"}, {31'd0, rsp_zero_o}, {31'd0, exp_z});
    if (id == 0) rsp0_ready_i = 1'b1; else rsp1_ready_i = 1'b1;
    tick();
    rsp0_ready_i = 1'b0;
    rsp1_ready_i = 1'b0;
    check({tag, "_done"}, {30'd0, rsp1_valid_o, rsp0_valid_o, 1'b0} | {31'd0, busy_o}, 32'd0);
  endtask

  logic [31:0] rr_y [2];
  int          got_id;
  int          n_wait;
  logic [CNT_W-1:0] exp_cnt0;

  initial begin
    reset_i = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0, 6'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 6'd0);
    req0_alt_ctrl_i2 = 2'd0; req1_alt_ctrl_i2 = 2'd0;
    rsp0_ready_i = 1'b0; rsp1_ready_i = 1'b0;
    tick(); tick();
    reset_i = 1'b0;
    #1;
    // Reset state
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp1_valid_o, rsp0_valid_o}, 32'd0);
    check("rst_y", rsp_y_o32, 32'd0);
    check("rst_alu_a", alu_a_o32, 32'd0);
    check("rst_cnt", {28'd0, grant_cnt1_o, grant_cnt0_o}, 32'd0);

    // Single op and zero flag
    run_op("add", 0, 32'd5, 32'd3, 6'h20, 32'd8, 1'b0);
    run_op("sub_zero", 1, 32'd7, 32'd7, 6'h22, 32'd0, 1'b1);

    // Round robin: both valid throughout, expect grants 0,1,0,1
    rr_y[0] = 32'd14;
    rr_y[1] = 32'd99;
    drive(0, 1'b1, 32'd10, 32'd4, 6'h20);
    drive(1, 1'b1, 32'd100, 32'd1, 6'h22);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_wait = 0;
      while (!req0_ready_o && !req1_ready_o && n_wait < 20) begin
        tick();
        n_wait++;
      end
      got_id = req1_ready_o ? 1 : 0;
      check($sformatf("rr%0d_grant", k), {30'd0, req1_ready_o, req0_ready_o},
            (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      tick();
      check($sformatf("rr%0d_rsp", k), {30'd0, rsp1_valid_o, rsp0_valid_o},
            (k % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("rr%0d_y", k), rsp_y_o32, rr_y[k % 2]);
      if (got_id == 0) rsp0_ready_i = 1'b1; else rsp1_ready_i = 1'b1;
      tick();
      rsp0_ready_i = 1'b0;
      rsp1_ready_i = 1'b0;
    end
    drive(0, 1'b0, 32'd0, 32'd0, 6'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 6'd0);

    // Backpressure on requester 0 with requester 1 waiting
    drive(0, 1'b1, 32'd1, 32'd2, 6'h20);
    #1;
    check("bp_acc", {31'd0, req0_ready_o}, 32'd1);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, 6'd0);
    tick();
    drive(1, 1'b1, 32'd9, 32'd9, 6'h22);
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("bp%0d_rsp", c), {30'd0, rsp1_valid_o, rsp0_valid_o}, 32'd1);
      check($sformatf("bp%0d_y", c), rsp_y_o32, 32'd3);
      check($sformatf("bp%0d_r1", c), {31'd0, req1_ready_o}, 32'd0);
      tick();
    end
    rsp0_ready_i = 1'b1;
    tick();
    rsp0_ready_i = 1'b0;
    #1;
    check("bp_next_acc", {31'd0, req1_ready_o}, 32'd1);
    tick();
    drive(1, 1'b0, 32'd0, 32'd0, 6'd0);
    tick();
    check("bp_r1_rsp", {30'd0, rsp1_valid_o, rsp0_valid_o}, 32'd2);
    check("bp_r1_zero", {31'd0, rsp_zero_o}, 32'd1);
    rsp1_ready_i = 1'b1;
    tick();
    rsp1_ready_i = 1'b0;

    // Reset while in EXEC
    drive(0, 1'b1, 32'd6, 32'd6, 6'h20);
    tick();
    drive(0, 1'b0, 32'd0, 32'd0, 6'd0);
    check("rx_in_exec", {31'd0, busy_o}, 32'd1);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    check("rx_busy", {31'd0, busy_o}, 32'd0);
    check("rx_alu_a", alu_a_o32, 32'd0);
    check("rx_y", rsp_y_o32, 32'd0);
    check("rx_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
    tick();
    check("rx_norsp", {30'd0, rsp1_valid_o, rsp0_valid_o}, 32'd0);
    drive(0, 1'b1, 32'd1, 32'd1, 6'h20);
    drive(1, 1'b1, 32'd2, 32'd2, 6'h20);
    #1;
    check("rx_tie", {30'd0, req1_ready_o, req0_ready_o}, 32'd1);
    drive(0, 1'b0, 32'd0, 32'd0, 6'd0);
    drive(1, 1'b0, 32'd0, 32'd0, 6'd0);

    // Grant counters: five requester-0 grants after a fresh reset
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    for (int g = 0; g < 5; g++) begin
      run_op($sformatf("perf%0d", g), 0, 32'(g), 32'd1, 6'h20, 32'(g + 1), 1'b0);
    end
`ifdef ALU_ARB_PERF_EN
    exp_cnt0 = 2'd3;
`else
    exp_cnt0 = 2'd0;
`endif
    check("perf_cnt0", {30'd0, grant_cnt0_o}, {30'd0, exp_cnt0});
    check("perf_cnt1", {30'd0, grant_cnt1_o}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
